// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise / debounce / edge detect with sticky pending flags and irq.
// Latency: SYNC_STAGES+1+filter_len clk edges from a stable level change to filtered/tick/pending.
// Backpressure: none; ticks are single-cycle pulses and pending holds events until cleared.
module multi_edge_detector #(
    parameter int CHANNELS     = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     level,
    input  logic [1:0]              edge_mode,
    input  logic [FILTER_WIDTH-1:0] filter_len,
    input  logic [CHANNELS-1:0]     clear,
    output logic [CHANNELS-1:0]     filtered,
    output logic [CHANNELS-1:0]     tick,
    output logic [CHANNELS-1:0]     edge_dir,
    output logic [CHANNELS-1:0]     pending,
    output logic                    irq
);

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_RISING  = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_FALLING = 2'd3;

    localparam logic [FILTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [FILTER_WIDTH-1:0] CNT_ONE = FILTER_WIDTH'(1);

    logic [CHANNELS-1:0]     r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0]     w_s;

    logic [1:0]              r_state     [CHANNELS];
    logic [1:0]              w_state_nxt [CHANNELS];
    logic [FILTER_WIDTH-1:0] r_cnt       [CHANNELS];
    logic [FILTER_WIDTH-1:0] w_cnt_nxt   [CHANNELS];
    logic [CHANNELS-1:0]     w_rise;
    logic [CHANNELS-1:0]     w_fall;

    logic [CHANNELS-1:0]     w_tick_nxt;
    logic [CHANNELS-1:0]     w_dir_nxt;
    logic [CHANNELS-1:0]     w_pending_nxt;
    logic [CHANNELS-1:0]     w_filtered_nxt;

    logic [CHANNELS-1:0]     r_filtered;
    logic [CHANNELS-1:0]     r_tick;
    logic [CHANNELS-1:0]     r_edge_dir;
    logic [CHANNELS-1:0]     r_pending;
    logic                    r_irq;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: raw levels are only ever seen through the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= level;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Per-channel debounce FSM state and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= ST_LOW;
                r_cnt[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
            end
        end
    end

    // Next-state logic; >= compare lets a shortened filter_len finish an in-flight count.
    always_comb begin
        w_rise = '0;
        w_fall = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_cnt[c];
            case (r_state[c])
                ST_LOW: begin
                    if (w_s[c]) begin
                        if (filter_len == '0) begin
                            w_state_nxt[c] = ST_HIGH;
                            w_cnt_nxt[c]   = '0;
                            w_rise[c]      = 1'b1;
                        end else begin
                            w_state_nxt[c] = ST_RISING;
                            w_cnt_nxt[c]   = CNT_ONE;
                        end
                    end
                end
                ST_RISING: begin
                    if (!w_s[c]) begin
                        w_state_nxt[c] = ST_LOW;
                        w_cnt_nxt[c]   = '0;
                    end else if (r_cnt[c] >= filter_len) begin
                        w_state_nxt[c] = ST_HIGH;
                        w_cnt_nxt[c]   = '0;
                        w_rise[c]      = 1'b1;
                    end else if (r_cnt[c] != CNT_MAX) begin
                        w_cnt_nxt[c]   = r_cnt[c] + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_s[c]) begin
                        if (filter_len == '0) begin
                            w_state_nxt[c] = ST_LOW;
                            w_cnt_nxt[c]   = '0;
                            w_fall[c]      = 1'b1;
                        end else begin
                            w_state_nxt[c] = ST_FALLING;
                            w_cnt_nxt[c]   = CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (w_s[c]) begin
                        w_state_nxt[c] = ST_HIGH;
                        w_cnt_nxt[c]   = '0;
                    end else if (r_cnt[c] >= filter_len) begin
                        w_state_nxt[c] = ST_LOW;
                        w_cnt_nxt[c]   = '0;
                        w_fall[c]      = 1'b1;
                    end else if (r_cnt[c] != CNT_MAX) begin
                        w_cnt_nxt[c]   = r_cnt[c] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Output decode: qualify events by edge_mode; a new event beats a same-cycle clear.
    always_comb begin
        w_tick_nxt     = (w_rise & {CHANNELS{edge_mode[0]}}) | (w_fall & {CHANNELS{edge_mode[1]}});
        w_dir_nxt      = w_rise & {CHANNELS{edge_mode[0]}};
        w_pending_nxt  = (r_pending & ~clear) | w_tick_nxt;
        w_filtered_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_filtered_nxt[c] = (w_state_nxt[c] == ST_HIGH) || (w_state_nxt[c] == ST_FALLING);
        end
    end

    // Register every output so nothing combinational reaches the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filtered <= '0;
            r_tick     <= '0;
            r_edge_dir <= '0;
            r_pending  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_filtered <= w_filtered_nxt;
            r_tick     <= w_tick_nxt;
            r_edge_dir <= w_dir_nxt;
            r_pending  <= w_pending_nxt;
            r_irq      <= |w_pending_nxt;
        end
    end

    assign filtered = r_filtered;
    assign tick     = r_tick;
    assign edge_dir = r_edge_dir;
    assign pending  = r_pending;
    assign irq      = r_irq;

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous level input, debounces it with a run-time programmable stability filter, and emits a one-cycle tick on a selectable edge polarity. Each channel also sets a sticky, software-clearable pending flag. The block sits between raw board inputs (buttons, external strobes) and control logic or an interrupt aggregator.

## Interface
- CHANNELS, 8: number of independent level inputs (1..32).
- SYNC_STAGES, 2: synchroniser flop depth per channel (>=2).
- FILTER_WIDTH, 4: width of the debounce counter and of `filter_len`.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- level  input  CHANNELS  raw asynchronous levels, one bit per channel.
- edge_mode  input  2  shared by all channels: 00 none, 01 rising, 10 falling, 11 both.
- filter_len  input  FILTER_WIDTH  extra stable cycles required; 0 means no debounce.
- clear  input  CHANNELS  write-one-to-clear for `pending`, sampled each clk.
- filtered  output  CHANNELS  debounced level per channel.
- tick  output  CHANNELS  one-cycle pulse on a qualifying edge.
- edge_dir  output  CHANNELS  1 for a rising edge, 0 for a falling edge; valid only while the matching `tick` bit is 1.
- pending  output  CHANNELS  sticky event flags.
- irq  output  1  OR of `pending`, registered.

## Operation
- Per channel there is a SYNC_STAGES flop chain; `s` is the output of the last stage. `level` is never used directly.
- Each channel runs a 4-state FSM: LOW, RISING, HIGH, FALLING. `filtered` is 1 in HIGH and FALLING, 0 otherwise. Each channel has a counter `cnt` of FILTER_WIDTH bits.
- LOW:
  - s=1 and filter_len=0: go to HIGH.
  - s=1 otherwise: go to RISING, cnt<=1.
- RISING:
  - s=0: back to LOW, cnt<=0. This is a glitch; no tick.
  - s=1 and cnt>=filter_len: go to HIGH, cnt<=0.
  - otherwise: cnt<=cnt+1.
- HIGH and FALLING mirror LOW and RISING with polarity inverted.
- Transition LOW/RISING->HIGH is a rising event. Transition HIGH/FALLING->LOW is a falling event.
- An event qualifies if its polarity is enabled in `edge_mode`, sampled on the same clk edge as the transition. On a qualifying event, `tick` is set for exactly one cycle, `edge_dir` is set to the event polarity, and the `pending` bit is set.
- Events that do not qualify still update `filtered` but do not touch `tick` or `pending`.
- `pending` is cleared when its `clear` bit is 1. If set and clear hit the same cycle, set wins.
- `irq` <= |pending_next, so `irq` tracks `pending` in the same cycle.
- `filter_len` may change at any time:
  - The `>=` compare guarantees completion when a count is already past the new value.
  - A RISING or FALLING count never hangs.
- The counter never wraps. The maximum count is 2^FILTER_WIDTH-1.
- Channels are fully independent. Only `edge_mode` and `filter_len` are shared.

## Timing
- Reset (async assert; release on a clk edge) sets:
  - all synchroniser flops to 0;
  - FSM state to LOW and cnt to 0;
  - `filtered`, `tick`, `edge_dir`, `pending` and `irq` to 0.
- A level that is high at reset release produces a normal rising event once filtered.
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: let `level` change and remain stable before clk edge 1.
  - `s` changes after edge SYNC_STAGES.
  - `filtered`, `tick` and `pending` change after edge SYNC_STAGES+1+filter_len.
  - With the defaults and filter_len=0, `tick` is high in the cycle after edge 3.
- Glitch rule: a change on `s` lasting <= filter_len cycles produces no event and no change on `filtered`.
- Minimum spacing between consecutive events on one channel is filter_len+1 cycles. Back-to-back ticks are possible only when filter_len=0 and `s` toggles every cycle.
- `edge_mode` or `filter_len` changes take effect on the next clk edge. An in-progress count is not restarted.
- Reset mid-count discards the count with no tick. `pending` is lost.

## Test plan
- filter_len=0, mode=11, ch0 level 0->1 held: `tick[0]` and `edge_dir[0]`=1 high for exactly one cycle after edge 3; `pending[0]`=1, `irq`=1.
- filter_len=3, ch2 high pulse of 3 cycles on `s` -> no tick and `filtered[2]` stays 0. A 4-cycle pulse -> rising tick after edge SYNC_STAGES+4, then a falling tick 4 cycles after the level drops.
- mode=01, ch1 0->1->0 with filter_len=0 -> one rising tick only. The falling edge updates `filtered[1]` but `pending` stays set and no second tick occurs.
- With `pending[5]`=1, assert `clear[5]` in the same cycle as a new qualifying event on ch5 -> `pending[5]` remains 1. Clear alone on the next cycle -> 0 and `irq`=0.
- All CHANNELS rising simultaneously, filter_len=2 -> all `tick` bits high in the same cycle.
- Assert `reset` mid-count (ch3 in RISING, cnt=2): all outputs 0 immediately. After release with `level[3]` still 1, one rising tick after SYNC_STAGES+1+filter_len edges.
